rf_wport_arb: RTL and testbench
===============================

# rf_wport_arb

Write-port arbiter for the 8 x 16-bit register file. It shares the file's single write port between two requesters:
- requester 0: pipeline writeback;
- requester 1: multi-cycle unit, e.g. load return or multiply.

Each requester uses a valid/ready handshake. Arbitration is round-robin. The block drives the register file's `writeregsel`/`writedata`/`write` from registered outputs, flags pending writes to the read ports for hazard logic, and detects handshake protocol violations.

## Interface
Parameters:
- `DW`, 16, data width
- `AW`, 3, register select width (2^AW registers)

Ports:
- `clk` input 1: clock, rising edge
- `rst` input 1: asynchronous, active-high reset
- `req0_valid` input 1: requester 0 has a write
- `req0_sel` input AW: requester 0 destination register
- `req0_data` input DW: requester 0 write data
- `req0_ready` output 1: requester 0 accepted this cycle
- `req1_valid`, `req1_sel`, `req1_data`, `req1_ready`: same as requester 0, for requester 1
- `writeregsel` output AW: to register file
- `writedata` output DW: to register file
- `write` output 1: register file write enable
- `read1regsel` input AW: register file read port 1 select (snooped)
- `read2regsel` input AW: register file read port 2 select (snooped)
- `rd1_pend` output 1: `write` is high and `writeregsel == read1regsel`
- `rd2_pend` output 1: `write` is high and `writeregsel == read2regsel`
- `err` output 1: sticky protocol-violation flag

## Operation
- Transfer: a request transfers on a rising edge where `reqN_valid & reqN_ready` is 1.
- Grant (combinational, from current valids and `last`):
  - Only one valid: grant that requester.
  - Both valid: grant the requester other than `last`.
  - `reqN_ready = grantN`. At most one ready is high per cycle; a ready is never high without its valid.
- `last` register: 1-bit, updates to the granted index on every transfer, holds otherwise. Reset value 1, so requester 0 wins the first contention.
- Output register, loaded every cycle:
  - `write <= any grant`.
  - On a grant, `writeregsel`/`writedata` load the granted sel/data.
  - With no grant, `writeregsel`/`writedata` hold their value.
- Same-destination contention: both requests are serialised in grant order. The later write lands last.
- Requester rule: once `reqN_valid` is high and not accepted, it must stay high with stable sel and data until accepted.
- Violation detection: the block registers per requester `waitN = reqN_valid & ~reqN_ready` with the sel/data captured. Next cycle, if `waitN` is set and either `reqN_valid` is low or the sel/data differ, `err` sets and stays high until reset.
- Pending flags `rd1_pend`/`rd2_pend`: purely combinational from the output register and `read1regsel`/`read2regsel`.

## Timing
- Reset values: `write`=0, `writeregsel`=0, `writedata`=0, `err`=0, `last`=1, `wait0`=`wait1`=0. `reqN_ready` is 0 while all valids are 0.
- Latency: a request accepted at edge E drives `write` during cycle E..E+1. The register file captures it at edge E+1. Total: 2 edges from valid to architectural update for an uncontended request.
- Throughput: one write per cycle.
- Contention: with both valid every cycle, grants strictly alternate; the worst-case wait for either requester is 1 cycle.
- Reset mid-operation:
  - Asynchronous clear of all state; any in-flight write in the output register is dropped (`write` falls immediately).
  - Requesters must re-present after reset deassertion.
- Reset deassertion: synchronous to `clk` externally; the block needs no internal synchroniser.

## Structure
- Shared package (`rf_pkg` or the existing processor defines file): `RF_DW=16`, `RF_AW=3`, requester index constants `REQ_WB=0`, `REQ_MC=1`.
- One natural sub-module: `rr_arb2`, a 2-way round-robin grant with its `last` pointer. All other logic (output register, violation tracking, pending compare) stays in `rf_wport_arb`.
- The output register is a plain flop bank with an async clear.

## Test plan
- Reset, then idle: `write`=0, readies 0, `err`=0.
- Single requester, uncontended: `req0` valid with sel=3, data=0x1234 for one cycle. Required: `req0_ready`=1 that cycle; next cycle `write`=1, `writeregsel`=3, `writedata`=0x1234; with `read1regsel`=3, `rd1_pend`=1.
- Contention, same cycle: `req0` (sel 1, 0xAAAA) and `req1` (sel 2, 0x5555) both valid after reset. Required: `req0` granted first and `req1` granted the following cycle; outputs show 1/0xAAAA, then 2/0x5555.
- Sustained contention: both valid for 6 cycles with distinct data. Required: grants alternate 0,1,0,1,0,1; no cycle has `write`=0.
- Same destination: both target reg 5 (0x1111 from `req0`, 0x2222 from `req1`). Required: after the contention resolves, register 5 reads 0x2222.
- Protocol violation and reset:
  - `req1` valid and waiting, then data changes while still unaccepted: required `err`=1 next cycle and stays 1.
  - Assert `rst` mid-stream: required `err`, `write` and `writedata` go to 0 immediately.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions: geometry, requester indices and the
// 2-way round-robin grant function used by the write-port arbiter.
package rf_pkg;

    localparam int RF_DW = 16;
    localparam int RF_AW = 3;

    localparam logic REQ_WB = 1'b0;
    localparam logic REQ_MC = 1'b1;

    // Lone requester wins; under contention the one that was not served last wins.
    function automatic logic [1:0] rr_grant(input logic [1:0] valid, input logic last);
        logic [1:0] g;
        g[0] = valid[0] & (~valid[1] | (last == REQ_MC));
        g[1] = valid[1] & (~valid[0] | (last == REQ_WB));
        return g;
    endfunction

endpackage

// File: rtl/rf_wport_arb_rr.sv
// Two-way round-robin arbiter: combinational grant plus the pointer to the
// most recently served requester.
module rr_arb2
    import rf_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    output logic [1:0] grant
);

    logic last;

    always_comb begin
        grant = rr_grant(valid, last);
    end

    // A grant always coincides with a transfer, since ready is the grant itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last <= REQ_MC;
        end else if (|grant) begin
            last <= grant[1];
        end
    end

endmodule

// File: rtl/rf_wport_arb.sv
// Write-port arbiter for the register file: round-robin between writeback and
// the multi-cycle unit, registered write port, hazard flags, protocol check.
module rf_wport_arb
    import rf_pkg::*;
#(
    parameter int DW = RF_DW,
    parameter int AW = RF_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_sel,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_sel,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    output logic [AW-1:0] writeregsel,
    output logic [DW-1:0] writedata,
    output logic          write,
    input  logic [AW-1:0] read1regsel,
    input  logic [AW-1:0] read2regsel,
    output logic          rd1_pend,
    output logic          rd2_pend,
    output logic          err
);

    // A waiting request broke the hold rule if it dropped or changed payload.
    function automatic logic req_broken(
        input logic          valid,
        input logic [AW-1:0] sel,
        input logic [DW-1:0] data,
        input logic [AW-1:0] held_sel,
        input logic [DW-1:0] held_data
    );
        return ~valid | (sel != held_sel) | (data != held_data);
    endfunction

    logic [1:0]    grant;
    logic          wait0;
    logic          wait1;
    logic [AW-1:0] wait_sel0;
    logic [AW-1:0] wait_sel1;
    logic [DW-1:0] wait_data0;
    logic [DW-1:0] wait_data1;
    logic          viol;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .valid ({req1_valid, req0_valid}),
        .grant (grant)
    );

    assign req0_ready = grant[REQ_WB];
    assign req1_ready = grant[REQ_MC];

    // ---- output register stage: drives the register file write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write       <= 1'b0;
            writeregsel <= '0;
            writedata   <= '0;
        end else begin
            write <= |grant;
            if (grant[REQ_WB]) begin
                writeregsel <= req0_sel;
                writedata   <= req0_data;
            end else if (grant[REQ_MC]) begin
                writeregsel <= req1_sel;
                writedata   <= req1_data;
            end
        end
    end

    assign rd1_pend = write & (writeregsel == read1regsel);
    assign rd2_pend = write & (writeregsel == read2regsel);

    // ---- violation tracking stage: remember who was left waiting and with what
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait0 <= 1'b0;
            wait1 <= 1'b0;
        end else begin
            wait0 <= req0_valid & ~req0_ready;
            wait1 <= req1_valid & ~req1_ready;
        end
    end

    always_ff @(posedge clk) begin
        wait_sel0  <= req0_sel;
        wait_data0 <= req0_data;
        wait_sel1  <= req1_sel;
        wait_data1 <= req1_data;
    end

    always_comb begin
        viol = (wait0 & req_broken(req0_valid, req0_sel, req0_data, wait_sel0, wait_data0))
             | (wait1 & req_broken(req1_valid, req1_sel, req1_data, wait_sel1, wait_data1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (viol) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rf_wport_arb.sv
// Directed bench for rf_wport_arb with a behavioural register-file model.
module tb_rf_wport_arb;

    localparam int DW = 16;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid;
    logic [AW-1:0] req0_sel, req1_sel;
    logic [DW-1:0] req0_data, req1_data;
    logic          req0_ready, req1_ready;
    logic [AW-1:0] writeregsel;
    logic [DW-1:0] writedata;
    logic          write;
    logic [AW-1:0] read1regsel, read2regsel;
    logic          rd1_pend, rd2_pend;
    logic          err;

    logic [DW-1:0] rf_m [0:7];
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    rf_wport_arb #(.DW(DW), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_sel    (req0_sel),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_sel    (req1_sel),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .writeregsel (writeregsel),
        .writedata   (writedata),
        .write       (write),
        .read1regsel (read1regsel),
        .read2regsel (read2regsel),
        .rd1_pend    (rd1_pend),
        .rd2_pend    (rd2_pend),
        .err         (err)
    );

    // Register file captures the write port on each rising edge.
    always @(posedge clk) begin
        if (write) rf_m[writeregsel] <= writedata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [DW-1:0] expd;
        int            g;

        rst = 1'b1;
        req0_valid = 1'b0; req0_sel = '0; req0_data = '0;
        req1_valid = 1'b0; req1_sel = '0; req1_data = '0;
        read1regsel = '0; read2regsel = '0;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset, then idle
        @(negedge clk);
        check("rst_write", write, 0);
        check("rst_sel", writeregsel, 0);
        check("rst_data", writedata, 0);
        check("rst_err", err, 0);
        check("rst_rdy0", req0_ready, 0);
        check("rst_rdy1", req1_ready, 0);

        // Single uncontended request
        drive_edge();
        req0_valid = 1'b1; req0_sel = 3'd3; req0_data = 16'h1234; read1regsel = 3'd3;
        @(negedge clk);
        check("single_rdy0", req0_ready, 1);
        check("single_rdy1", req1_ready, 0);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check("single_write", write, 1);
        check("single_sel", writeregsel, 3);
        check("single_data", writedata, 16'h1234);
        check("single_rd1p", rd1_pend, 1);
        check("single_rd2p", rd2_pend, 0);
        drive_edge();
        @(negedge clk);
        check("single_idle_write", write, 0);
        check("single_idle_rd1p", rd1_pend, 0);

        // Fresh reset so the pointer favours requester 0
        rst = 1'b1;
        drive_edge();
        rst = 1'b0;

        // Same-cycle contention
        req0_valid = 1'b1; req0_sel = 3'd1; req0_data = 16'hAAAA;
        req1_valid = 1'b1; req1_sel = 3'd2; req1_data = 16'h5555;
        read1regsel = 3'd1; read2regsel = 3'd2;
        @(negedge clk);
        check("cont_rdy0", req0_ready, 1);
        check("cont_rdy1", req1_ready, 0);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check("cont_w1_write", write, 1);
        check("cont_w1_sel", writeregsel, 1);
        check("cont_w1_data", writedata, 16'hAAAA);
        check("cont_w1_rd1p", rd1_pend, 1);
        check("cont_w1_rd2p", rd2_pend, 0);
        check("cont_rdy1_2", req1_ready, 1);
        drive_edge();
        req1_valid = 1'b0;
        @(negedge clk);
        check("cont_w2_write", write, 1);
        check("cont_w2_sel", writeregsel, 2);
        check("cont_w2_data", writedata, 16'h5555);
        check("cont_w2_rd2p", rd2_pend, 1);

        // Sustained contention: grants must alternate 0,1,0,1,0,1
        drive_edge();
        req0_valid = 1'b1; req0_sel = 3'd6; req0_data = 16'h0100;
        req1_valid = 1'b1; req1_sel = 3'd7; req1_data = 16'h0200;
        expd = '0;
        for (int i = 0; i < 6; i++) begin
            g = i % 2;
            @(negedge clk);
            check("alt_rdy0", req0_ready, (g == 0));
            check("alt_rdy1", req1_ready, (g == 1));
            if (i > 0) begin
                check("alt_write", write, 1);
                check("alt_data", writedata, expd);
            end
            expd = (g == 1) ? req1_data : req0_data;
            drive_edge();
            if (g == 0) req0_data = req0_data + 16'd1;
            else        req1_data = req1_data + 16'd1;
            if (i == 4) req0_valid = 1'b0;
            if (i == 5) req1_valid = 1'b0;
        end
        @(negedge clk);
        check("alt_last_write", write, 1);
        check("alt_last_data", writedata, 16'h0202);
        check("alt_err", err, 0);

        // Same destination: the later grant (requester 1) must land last
        drive_edge();
        req0_valid = 1'b1; req0_sel = 3'd5; req0_data = 16'h1111;
        req1_valid = 1'b1; req1_sel = 3'd5; req1_data = 16'h2222;
        @(negedge clk);
        check("same_rdy0", req0_ready, 1);
        drive_edge();
        req0_valid = 1'b0;
        @(negedge clk);
        check("same_rdy1", req1_ready, 1);
        drive_edge();
        req1_valid = 1'b0;
        drive_edge();
        @(negedge clk);
        check("same_reg5", rf_m[5], 16'h2222);

        // Protocol violation: requester 1 changes data while waiting
        drive_edge();
        req0_valid = 1'b1; req0_sel = 3'd0; req0_data = 16'h0000;
        req1_valid = 1'b1; req1_sel = 3'd4; req1_data = 16'hBEEF;
        @(negedge clk);
        check("viol_rdy1", req1_ready, 0);
        check("viol_err_pre", err, 0);
        drive_edge();
        req0_valid = 1'b0;
        req1_data  = 16'hBEEE;
        @(negedge clk);
        check("viol_err_lat", err, 0);
        drive_edge();
        req1_valid = 1'b0;
        @(negedge clk);
        check("viol_err_set", err, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("viol_err_sticky", err, 1);

        // Reset mid-stream drops the in-flight write at once
        drive_edge();
        req0_valid = 1'b1; req0_sel = 3'd2; req0_data = 16'h7777;
        drive_edge();
        @(negedge clk);
        check("mid_write", write, 1);
        check("mid_data", writedata, 16'h7777);
        rst = 1'b1;
        req0_valid = 1'b0;
        #1;
        check("mid_rst_err", err, 0);
        check("mid_rst_write", write, 0);
        check("mid_rst_data", writedata, 0);
        check("mid_rst_sel", writeregsel, 0);
        drive_edge();
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_write", write, 0);
        check("post_rst_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
